alu_dword_sequencer: RTL and testbench

Two-cycle sequencer that performs 64-bit operations on the shared 32-bit ALU by issuing the low half, capturing carry/borrow, then issuing the high half with that carry chained in. Arbitrates between two requesters (integer pipe and PPU address/utility path), owns the ALU operand/opcode inputs while busy, and returns a 64-bit result plus combined flags over a valid/ready response channel.

---
 rtl/alu_dword_sequencer_if.sv | 41 ++++
 rtl/alu_dword_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_dword_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_dword_sequencer_if.sv
// Request, response and shared-ALU signal bundle for alu_dword_sequencer.
// The sequencer takes the slave modport; requesters, consumer and the ALU together form the master side.
interface alu_dword_sequencer_if #(
  parameter int HALF_W = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_op0;
  logic [1:0]          req_op1;
  logic [2*HALF_W-1:0] req_a0;
  logic [2*HALF_W-1:0] req_b0;
  logic [2*HALF_W-1:0] req_a1;
  logic [2*HALF_W-1:0] req_b1;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [2*HALF_W-1:0] rsp_data;
  logic [3:0]          rsp_flags;

  logic [HALF_W-1:0]   alu_a;
  logic [HALF_W-1:0]   alu_b;
  logic [3:0]          alu_op;
  logic                alu_ci;
  logic [HALF_W-1:0]   alu_out;
  logic [3:0]          alu_flags;

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    input  rsp_ready, alu_out, alu_flags,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags,
    output alu_a, alu_b, alu_op, alu_ci
  );

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
    output rsp_ready, alu_out, alu_flags,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags,
    input  alu_a, alu_b, alu_op, alu_ci
  );
endinterface

// File: rtl/alu_dword_sequencer.sv
// Runs 64-bit ADD/SUB/AND/XOR on a shared 32-bit ALU: low half first, then high half with carry/borrow chained.
// Define ALU_SEQ_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_dword_sequencer #(
  parameter int HALF_W = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  alu_dword_sequencer_if.slave bus
);
  localparam int DW = 2 * HALF_W;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RSP} state_e;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_AND, OP_XOR} op_e;

  // Opcode bit 0 selects the carry-chained form for the high half of ADD/SUB.
  function automatic logic [3:0] alu_opcode(input op_e op, input logic hi_half);
    case (op)
      OP_ADD:  alu_opcode = {3'b000, hi_half};
      OP_SUB:  alu_opcode = {3'b001, hi_half};
      OP_AND:  alu_opcode = 4'b0111;
      default: alu_opcode = 4'b0110;
    endcase
  endfunction

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DW-1:0]     a_q, a_d, b_q, b_d;
  logic              id_q, id_d;
  logic [HALF_W-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic              carry_q, carry_d;
  logic              zlo_q, zlo_d;
  logic [3:0]        flags_q, flags_d;

  logic       grant;
  logic [1:0] ready;
  logic       accept;
  logic       arith;

`ifdef ALU_SEQ_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  assign grant = (&bus.req_valid) ? ptr_q : bus.req_valid[1];
  // Point at the requester that did not just win.
  assign ptr_d = accept ? ~grant : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`else
  assign grant = ~bus.req_valid[0];
`endif

  // Ready is held low during reset so nothing can be accepted while the state is forced.
  assign ready  = (rst_n && state_q == S_IDLE && |bus.req_valid) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign accept = |(bus.req_valid & ready);
  assign arith  = (op_q == OP_ADD) || (op_q == OP_SUB);

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state_q == S_RSP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = {res_hi_q, res_lo_q};
  assign bus.rsp_flags = flags_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    res_lo_d   = res_lo_q;
    res_hi_d   = res_hi_q;
    carry_d    = carry_q;
    zlo_d      = zlo_q;
    flags_d    = flags_q;
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    bus.alu_op = 4'b0000;
    bus.alu_ci = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          id_d    = grant;
          op_d    = op_e'(grant ? bus.req_op1 : bus.req_op0);
          a_d     = grant ? bus.req_a1 : bus.req_a0;
          b_d     = grant ? bus.req_b1 : bus.req_b0;
          state_d = S_LO;
        end
      end
      S_LO: begin
        bus.alu_a  = a_q[HALF_W-1:0];
        bus.alu_b  = b_q[HALF_W-1:0];
        bus.alu_op = alu_opcode(op_q, 1'b0);
        res_lo_d   = bus.alu_out;
        carry_d    = bus.alu_flags[1];
        zlo_d      = bus.alu_flags[3];
        state_d    = S_HI;
      end
      S_HI: begin
        bus.alu_a  = a_q[DW-1:HALF_W];
        bus.alu_b  = b_q[DW-1:HALF_W];
        bus.alu_op = alu_opcode(op_q, 1'b1);
        bus.alu_ci = arith & carry_q;
        res_hi_d   = bus.alu_out;
        // Logic ops carry no meaningful C/V; Z must cover both halves.
        flags_d    = {zlo_q & bus.alu_flags[3], bus.alu_flags[2],
                      arith & bus.alu_flags[1], arith & bus.alu_flags[0]};
        state_d    = S_RSP;
      end
      S_RSP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, since rsp_data/rsp_flags must read zero out of reset.
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      carry_q  <= 1'b0;
      zlo_q    <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      carry_q  <= carry_d;
      zlo_q    <= zlo_d;
      flags_q  <= flags_d;
    end
  end
endmodule

// File: tb/tb_alu_dword_sequencer.sv
// Self-checking bench for alu_dword_sequencer: a behavioural 32-bit ALU, directed vector table,
// hand-written arbitration/stall/reset sequences, and random requests against a 64-bit arithmetic model.
module tb_alu_dword_sequencer;
  localparam int         HALF_W = 32;
  localparam logic [1:0] ADD    = 2'b00;
  localparam logic [1:0] SUB    = 2'b01;
  localparam logic [1:0] AND_OP = 2'b10;
  localparam logic [1:0] XOR_OP = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic model_ptr;

  alu_dword_sequencer_if #(.HALF_W(HALF_W)) bus ();
  alu_dword_sequencer #(.HALF_W(HALF_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Shared 32-bit ALU. Logic ops deliberately report C=V=1 so the sequencer must mask them.
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op, input logic ci);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'b0000, 4'b0001: begin
        w = {1'b0, a} + {1'b0, b} + {32'd0, op[0] & ci};
        r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'b0010, 4'b0011: begin
        w = {1'b0, a} - {1'b0, b} - {32'd0, op[0] & ci};
        r = w[31:0]; c = w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'b0111: begin r = a & b; c = 1'b1; v = 1'b1; end
      4'b0110: begin r = a ^ b; c = 1'b1; v = 1'b1; end
      default: r = 32'hDEAD_BEEF;
    endcase
    return {r == 32'd0, r[31], c, v, r};
  endfunction

  assign {bus.alu_flags, bus.alu_out} = alu_model(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_ci);

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  flags;
  } res_t;

  // 64-bit reference: plain wide arithmetic, C is borrow for SUB.
  function automatic res_t ref_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    res_t        r;
    logic [64:0] w;
    logic        c, v;
    c = 1'b0; v = 1'b0;
    case (op)
      ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r.data = w[63:0]; c = w[64];
        v = (a[63] == b[63]) && (r.data[63] != a[63]);
      end
      SUB: begin
        r.data = a - b; c = (a < b);
        v = (a[63] != b[63]) && (r.data[63] != a[63]);
      end
      AND_OP:  r.data = a & b;
      default: r.data = a ^ b;
    endcase
    r.flags = {r.data == 64'd0, r.data[63], c, v};
    return r;
  endfunction

  function automatic logic [3:0] exp_opcode(input logic [1:0] op, input logic hi);
    case (op)
      ADD:     return hi ? 4'b0001 : 4'b0000;
      SUB:     return hi ? 4'b0011 : 4'b0010;
      AND_OP:  return 4'b0111;
      default: return 4'b0110;
    endcase
  endfunction

  function automatic logic exp_carry(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [32:0] s;
    s = {1'b0, a[31:0]} + {1'b0, b[31:0]};
    if (op == ADD) return s[32];
    if (op == SUB) return a[31:0] < b[31:0];
    return 1'b0;
  endfunction

  function automatic logic pick(input logic [1:0] v, input logic p);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
`ifdef ALU_SEQ_ROUND_ROBIN_EN
    return p;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] rand64();
    logic [63:0] x;
    case ($urandom_range(0, 3))
      0:       x = {$urandom, $urandom};
      1:       x = {$urandom, 32'hFFFF_FFFF};
      2:       x = {32'h0, $urandom};
      default: x = {$urandom, 32'h0};
    endcase
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(input string tag, output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " rsp_valid"}, bus.rsp_valid, 1);
  endtask

  task automatic check_alu_idle(input string tag);
    check({tag, " alu idle"}, {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_ci}, 0);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("reset rsp_valid", bus.rsp_valid, 0);
    check("reset rsp_id", bus.rsp_id, 0);
    check("reset rsp_data", bus.rsp_data, 0);
    check("reset rsp_flags", bus.rsp_flags, 0);
    check("reset req_ready", bus.req_ready, 0);
    check_alu_idle("reset");
    @(negedge clk);
    rst_n         = 1'b1;
    bus.req_valid = 2'b00;
    model_ptr     = 1'b0;
  endtask

  // One full transaction from request to response handshake, with ALU-side checks in LO and HI.
  task automatic run_op(input string tag, input logic [1:0] vmask,
                        input logic [1:0] op0, input logic [63:0] a0, input logic [63:0] b0,
                        input logic [1:0] op1, input logic [63:0] a1, input logic [63:0] b1,
                        input int stall, input logic exp_g,
                        input logic [63:0] exp_d, input logic [3:0] exp_f);
    logic [1:0]  gop;
    logic [63:0] ga, gb;
    int          lat;
    gop = exp_g ? op1 : op0;
    ga  = exp_g ? a1 : a0;
    gb  = exp_g ? b1 : b0;
    @(negedge clk);
    bus.req_valid = vmask;
    bus.req_op0 = op0; bus.req_a0 = a0; bus.req_b0 = b0;
    bus.req_op1 = op1; bus.req_a1 = a1; bus.req_b1 = b1;
    #1;
    check({tag, " req_ready"}, bus.req_ready, exp_g ? 2'b10 : 2'b01);
    @(posedge clk);
    @(negedge clk);
    // Dropping valid and scrambling operands must not disturb the latched op.
    bus.req_valid = 2'b00;
    bus.req_a0 = ~a0; bus.req_b0 = ~b0; bus.req_a1 = ~a1; bus.req_b1 = ~b1;
    #1;
    check({tag, " lo alu_a"}, bus.alu_a, ga[31:0]);
    check({tag, " lo alu_b"}, bus.alu_b, gb[31:0]);
    check({tag, " lo alu_op"}, bus.alu_op, exp_opcode(gop, 1'b0));
    check({tag, " lo alu_ci"}, bus.alu_ci, 0);
    check({tag, " lo rsp_valid"}, bus.rsp_valid, 0);
    @(negedge clk);
    check({tag, " hi alu_a"}, bus.alu_a, ga[63:32]);
    check({tag, " hi alu_b"}, bus.alu_b, gb[63:32]);
    check({tag, " hi alu_op"}, bus.alu_op, exp_opcode(gop, 1'b1));
    check({tag, " hi alu_ci"}, bus.alu_ci, exp_carry(gop, ga, gb));
    check({tag, " hi rsp_valid"}, bus.rsp_valid, 0);
    @(negedge clk);
    wait_rsp(tag, lat);
    check({tag, " latency"}, lat, 0);
    for (int i = 0; i < stall; i++) begin
      bus.req_valid = 2'b11;
      #1;
      check({tag, " stall req_ready"}, bus.req_ready, 0);
      check({tag, " stall rsp"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_flags}, {1'b1, exp_g, exp_f});
      check({tag, " stall rsp_data"}, bus.rsp_data, exp_d);
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    check({tag, " rsp_id"}, bus.rsp_id, exp_g);
    check({tag, " rsp_data"}, bus.rsp_data, exp_d);
    check({tag, " rsp_flags"}, bus.rsp_flags, exp_f);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check({tag, " rsp_valid after handshake"}, bus.rsp_valid, 0);
    check_alu_idle(tag);
    model_ptr = ~exp_g;
  endtask

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    int          stall;
    logic [63:0] exp_data;
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[9];

  initial begin
    res_t        r;
    logic [1:0]  vm, op0, op1;
    logic [63:0] a0, b0, a1, b1;
    logic        g;
    int          lat;
    logic        seen;

    // {id, op, A, B, stall, expected data, expected {Z,N,C,V}}
    vecs[0] = '{1'b0, ADD,    64'h00000000_FFFFFFFF, 64'h00000000_00000001, 0, 64'h00000001_00000000, 4'b0000};
    vecs[1] = '{1'b1, SUB,    64'h00000001_00000000, 64'h00000000_00000001, 0, 64'h00000000_FFFFFFFF, 4'b0000};
    vecs[2] = '{1'b0, SUB,    64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 5, 64'h00000000_00000000, 4'b1000};
    vecs[3] = '{1'b1, AND_OP, 64'hFFFF0000_0000FFFF, 64'h0F0F0F0F_F0F0F0F0, 0, 64'h0F0F0000_0000F0F0, 4'b0000};
    vecs[4] = '{1'b0, ADD,    64'h7FFFFFFF_FFFFFFFF, 64'h00000000_00000001, 1, 64'h80000000_00000000, 4'b0101};
    vecs[5] = '{1'b1, ADD,    64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000001, 0, 64'h00000000_00000000, 4'b1010};
    vecs[6] = '{1'b0, XOR_OP, 64'hAAAAAAAA_00000000, 64'h55555555_00000000, 0, 64'hFFFFFFFF_00000000, 4'b0100};
    vecs[7] = '{1'b1, XOR_OP, 64'h00000000_0000FFFF, 64'h00000000_00000000, 0, 64'h00000000_0000FFFF, 4'b0000};
    vecs[8] = '{1'b0, SUB,    64'h00000000_00000000, 64'h00000000_00000001, 0, 64'hFFFFFFFF_FFFFFFFF, 4'b0110};

    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    bus.req_op0 = ADD; bus.req_op1 = ADD;
    bus.req_a0 = '0; bus.req_b0 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
    do_reset();

    // Directed vectors; the idle requester's slot carries inverted junk.
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].id == 1'b0)
        run_op($sformatf("vec%0d", i), 2'b01, vecs[i].op, vecs[i].a, vecs[i].b,
               ~vecs[i].op, ~vecs[i].a, ~vecs[i].b, vecs[i].stall, 1'b0,
               vecs[i].exp_data, vecs[i].exp_flags);
      else
        run_op($sformatf("vec%0d", i), 2'b10, ~vecs[i].op, ~vecs[i].a, ~vecs[i].b,
               vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].stall, 1'b1,
               vecs[i].exp_data, vecs[i].exp_flags);
    end

    // Both requesters held valid across two back-to-back ops.
    do_reset();
    op0 = ADD;    a0 = 64'h00000001_00000001; b0 = 64'h00000002_FFFFFFFF;
    op1 = XOR_OP; a1 = 64'hF0F0F0F0_12345678; b1 = 64'h0FF00FF0_12345678;
    @(negedge clk);
    bus.req_valid = 2'b11;
    bus.req_op0 = op0; bus.req_a0 = a0; bus.req_b0 = b0;
    bus.req_op1 = op1; bus.req_a1 = a1; bus.req_b1 = b1;
    #1;
    check("both first req_ready", bus.req_ready, 2'b01);
    @(posedge clk);
    @(negedge clk);
    wait_rsp("both first", lat);
    r = ref_op(op0, a0, b0);
    check("both first rsp_id", bus.rsp_id, 0);
    check("both first rsp_data", bus.rsp_data, r.data);
    bus.rsp_ready = 1'b1;
    #1;
    check("both handshake req_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    g = pick(2'b11, 1'b1);
    #1;
    check("both second req_ready", bus.req_ready, g ? 2'b10 : 2'b01);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 2'b00;
    wait_rsp("both second", lat);
    r = g ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
    check("both second rsp_id", bus.rsp_id, g);
    check("both second rsp_data", bus.rsp_data, r.data);
    check("both second rsp_flags", bus.rsp_flags, r.flags);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // Reset asserted while the high half is in flight.
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_op0 = ADD; bus.req_a0 = 64'h00000000_FFFFFFFF; bus.req_b0 = 64'h1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("midreset in HI alu_ci", bus.alu_ci, 1);
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    check("midreset rsp_valid", bus.rsp_valid, 0);
    check_alu_idle("midreset");
    check("midreset req_ready", bus.req_ready, 0);
    check("midreset rsp_data", bus.rsp_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 1'b0;
    #1;
    check("post-reset req_ready", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | bus.rsp_valid;
    end
    check("post-reset no response", seen, 0);

    // Random traffic against the wide-arithmetic model.
    for (int it = 0; it < 80; it++) begin
      vm  = 2'($urandom_range(1, 3));
      op0 = 2'($urandom_range(0, 3));
      op1 = 2'($urandom_range(0, 3));
      a0 = rand64(); b0 = rand64(); a1 = rand64(); b1 = rand64();
      g  = pick(vm, model_ptr);
      r  = g ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
      run_op($sformatf("rnd%0d", it), vm, op0, a0, b0, op1, a1, b1,
             $urandom_range(0, 2), g, r.data, r.flags);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
